event_counter: RTL and testbench

EVENT_COUNTER -- requirements
Module: event_counter

---
 rtl/event_counter_pkg.sv | 11 +
 rtl/event_counter_if.sv | 27 ++
 rtl/event_prescaler.sv | 31 +++
 rtl/event_counter.sv | 82 ++++++++
 tb/tb_event_counter.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/event_counter_pkg.sv
// Shared constants and helpers for the event counter slice.
package event_counter_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // Prescaler counter width; at least one bit so PRESCALE=1 still builds.
   function automatic int psc_width(input int prescale);
      return (prescale <= 2) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/event_counter_if.sv
// Request and status bundle between the event counter and whoever drives it.
import event_counter_pkg::*;

interface event_counter_if #(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             inc;
   logic             dec;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] count;
   logic             zero;
   logic             tc;
   logic             ovf;
   logic             unf;

   modport master (
      output inc, dec, clear, load, load_value,
      input  count, zero, tc, ovf, unf
   );

   modport slave (
      input  inc, dec, clear, load, load_value,
      output count, zero, tc, ovf, unf
   );
endinterface

// File: rtl/event_prescaler.sv
// Divides inc events by PRESCALE; tick fires on the PRESCALE-th event.
// Only instantiated when EVENT_COUNTER_PRESCALE_EN is defined.
module event_prescaler
   import event_counter_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic ev,
   output logic tick
);
   localparam int            PW   = psc_width(PRESCALE);
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q;

   assign tick = ev & ~clr & (cnt_q == LAST);

   // Event counter, restarts on clr and after each tick.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (ev) begin
         cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
      end
   end
endmodule

// File: rtl/event_counter.sv
// Up/down event counter with clear/load, limit pulse and sticky flags.
// Optional inc prescaler enabled by defining EVENT_COUNTER_PRESCALE_EN.
module event_counter
   import event_counter_pkg::*;
#(
   parameter int               WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
   parameter bit               SATURATE  = 1'b0,
   parameter int               PRESCALE  = 1
) (
   input  logic          clock,
   input  logic          reset,
   event_counter_if.slave bus
);
   logic             up_req;
   logic             down_req;
   logic             up_step;
   logic [WIDTH-1:0] count_q;
   logic             tc_q;
   logic             ovf_q;
   logic             unf_q;

   // inc and dec together cancel out.
   assign up_req   = bus.inc & ~bus.dec;
   assign down_req = bus.dec & ~bus.inc;

`ifdef EVENT_COUNTER_PRESCALE_EN
   event_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock (clock),
      .reset (reset),
      .clr   (bus.clear | bus.load),
      .ev    (up_req),
      .tick  (up_step)
   );
`else
   wire unused_prescale = (PRESCALE != 0);
   assign up_step = up_req;
`endif

   // Count register and flags; clear beats load beats inc/dec.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         tc_q <= 1'b0;
         if (bus.clear) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
         end else if (bus.load) begin
            count_q <= (bus.load_value > MAX_COUNT) ? MAX_COUNT : bus.load_value;
         end else if (up_step) begin
            if (count_q == MAX_COUNT) begin
               count_q <= SATURATE ? MAX_COUNT : '0;
               tc_q    <= 1'b1;
               ovf_q   <= 1'b1;
            end else begin
               count_q <= count_q + WIDTH'(1);
            end
         end else if (down_req) begin
            if (count_q == '0) begin
               count_q <= SATURATE ? '0 : MAX_COUNT;
               tc_q    <= 1'b1;
               unf_q   <= 1'b1;
            end else begin
               count_q <= count_q - WIDTH'(1);
            end
         end
      end
   end

   assign bus.count = count_q;
   assign bus.zero  = (count_q == '0);
   assign bus.tc    = tc_q;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;
endmodule

// File: tb/tb_event_counter.sv
// Drives three counter configurations with identical stimulus and checks each
// against a behavioural model through a scoreboard queue.
module tb_event_counter;
   logic       clock = 1'b0;
   logic       reset;
   logic       inc, dec, clear, load;
   logic [7:0] lv;

   int errors = 0;
   int checks = 0;

   always #5 clock = ~clock;

   event_counter_if #(.WIDTH(4)) bus_a ();
   event_counter_if #(.WIDTH(4)) bus_b ();
   event_counter_if #(.WIDTH(8)) bus_c ();

   assign bus_a.inc = inc;  assign bus_a.dec = dec;  assign bus_a.clear = clear;
   assign bus_a.load = load; assign bus_a.load_value = lv[3:0];
   assign bus_b.inc = inc;  assign bus_b.dec = dec;  assign bus_b.clear = clear;
   assign bus_b.load = load; assign bus_b.load_value = lv[3:0];
   assign bus_c.inc = inc;  assign bus_c.dec = dec;  assign bus_c.clear = clear;
   assign bus_c.load = load; assign bus_c.load_value = lv;

   // a: 4-bit wrap, prescale 3 (when enabled); b: 4-bit saturate; c: 8-bit, max 12
   event_counter #(.WIDTH(4), .SATURATE(1'b0), .PRESCALE(3)) dut_a (
      .clock(clock), .reset(reset), .bus(bus_a));
   event_counter #(.WIDTH(4), .SATURATE(1'b1), .PRESCALE(1)) dut_b (
      .clock(clock), .reset(reset), .bus(bus_b));
   event_counter #(.WIDTH(8), .MAX_COUNT(8'd12), .SATURATE(1'b0), .PRESCALE(1)) dut_c (
      .clock(clock), .reset(reset), .bus(bus_c));

   typedef struct {
      int count;
      bit tc;
      bit ovf;
      bit unf;
      int psc;
   } mstate_t;

   typedef struct {
      logic [11:0] v [3];
   } exp_t;

   mstate_t ms [3];
   exp_t    sb [$];

   function automatic int cfg_width(input int i);
      return (i == 2) ? 8 : 4;
   endfunction
   function automatic int cfg_max(input int i);
      return (i == 2) ? 12 : 15;
   endfunction
   function automatic bit cfg_sat(input int i);
      return (i == 1);
   endfunction
   function automatic int cfg_pre(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   function automatic mstate_t step(input mstate_t s, input int i, input bit i_inc,
                                    input bit i_dec, input bit i_clr, input bit i_ld,
                                    input int lvi);
      mstate_t n;
      int      mx;
      int      v;
      bit      t;
      n    = s;
      n.tc = 1'b0;
      mx   = cfg_max(i);
      v    = lvi & ((1 << cfg_width(i)) - 1);
      t    = 1'b1;
      if (i_clr) begin
         n.count = 0; n.ovf = 0; n.unf = 0; n.psc = 0;
      end else if (i_ld) begin
         n.count = (v > mx) ? mx : v;
         n.psc   = 0;
      end else if (i_inc && !i_dec) begin
`ifdef EVENT_COUNTER_PRESCALE_EN
         n.psc = s.psc + 1;
         if (n.psc >= cfg_pre(i)) n.psc = 0;
         else t = 1'b0;
`endif
         if (t) begin
            if (s.count == mx) begin
               n.tc = 1; n.ovf = 1;
               n.count = cfg_sat(i) ? mx : 0;
            end else begin
               n.count = s.count + 1;
            end
         end
      end else if (i_dec && !i_inc) begin
         if (s.count == 0) begin
            n.tc = 1; n.unf = 1;
            n.count = cfg_sat(i) ? 0 : mx;
         end else begin
            n.count = s.count - 1;
         end
      end
      return n;
   endfunction

   function automatic logic [11:0] pack(input mstate_t s);
      logic [7:0] c;
      c = 8'(s.count);
      return {c, (s.count == 0), s.tc, s.ovf, s.unf};
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.v[0] = {4'b0, bus_a.count, bus_a.zero, bus_a.tc, bus_a.ovf, bus_a.unf};
      o.v[1] = {4'b0, bus_b.count, bus_b.zero, bus_b.tc, bus_b.ovf, bus_b.unf};
      o.v[2] = {bus_c.count, bus_c.zero, bus_c.tc, bus_c.ovf, bus_c.unf};
      return o;
   endfunction

   task automatic compare(input string tag, input exp_t e);
      exp_t o;
      o = observe();
      for (int i = 0; i < 3; i++) begin
         checks++;
         assert (o.v[i] === e.v[i]) else begin
            errors++;
            $error("FAIL %s dut%0d observed={count,zero,tc,ovf,unf}=%h expected=%h",
                   tag, i, o.v[i], e.v[i]);
         end
      end
   endtask

   // Drive one cycle of stimulus, predict, then compare once the edge has acted.
   task automatic cycle(input string tag, input bit i_inc, input bit i_dec,
                        input bit i_clr, input bit i_ld, input int lvi);
      exp_t e;
      inc = i_inc; dec = i_dec; clear = i_clr; load = i_ld; lv = 8'(lvi);
      for (int i = 0; i < 3; i++) begin
         ms[i]  = step(ms[i], i, i_inc, i_dec, i_clr, i_ld, lvi);
         e.v[i] = pack(ms[i]);
      end
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         compare(tag, sb.pop_front());
      end
   endtask

   task automatic model_reset();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         ms[i]  = '{count: 0, tc: 0, ovf: 0, unf: 0, psc: 0};
         e.v[i] = pack(ms[i]);
      end
      sb.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      inc = 0; dec = 0; clear = 0; load = 0; lv = '0;
      #1;
      model_reset();
      compare("reset_state", sb.pop_front());
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Flags set, then mid-cycle reset clears everything without an edge.
      cycle("load15",        0, 0, 0, 1, 15);
      cycle("inc_at_max",    1, 0, 0, 0, 0);
      cycle("load5",         0, 0, 0, 1, 5);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare("async_reset", sb.pop_front());
      #1;
      reset = 1'b0;
      cycle("post_reset_idle", 0, 0, 0, 0, 0);

      // Wrap / saturate at the top, tc one cycle, ovf sticky until clear.
      cycle("wrap_load15",   0, 0, 0, 1, 15);
      cycle("wrap_inc",      1, 0, 0, 0, 0);
      cycle("wrap_inc2",     1, 0, 0, 0, 0);
      cycle("wrap_inc3",     1, 0, 0, 0, 0);
      cycle("wrap_idle1",    0, 0, 0, 0, 0);
      cycle("wrap_idle2",    0, 0, 0, 0, 0);
      cycle("wrap_clear",    0, 0, 1, 0, 0);

      // Down-crossing at zero twice in a row.
      cycle("sat_dec1",      0, 1, 0, 0, 0);
      cycle("sat_dec2",      0, 1, 0, 0, 0);
      cycle("sat_idle",      0, 0, 0, 0, 0);

      // Priority and load clamping.
      cycle("prio_load3",    0, 0, 0, 1, 3);
      cycle("prio_clr_ld_inc", 1, 0, 1, 1, 7);
      cycle("load20",        0, 0, 0, 1, 20);
      cycle("load_inc_prio", 1, 1, 0, 1, 9);

      // inc&dec cancels; ordinary decrement does not pulse tc.
      cycle("load3",         0, 0, 0, 1, 3);
      cycle("inc_and_dec",   1, 1, 0, 0, 0);
      cycle("load9",         0, 0, 0, 1, 9);
      cycle("dec_from9",     0, 1, 0, 0, 0);

      // Seven inc pulses from zero.
      cycle("pulse_clear",   0, 0, 1, 0, 0);
      for (int k = 0; k < 7; k++) begin
         cycle("pulse_inc",  1, 0, 0, 0, 0);
         cycle("pulse_gap",  0, 0, 0, 0, 0);
      end

      // Load in the middle of a prescale run restarts it.
      cycle("restart_clear", 0, 0, 1, 0, 0);
      cycle("restart_inc1",  1, 0, 0, 0, 0);
      cycle("restart_inc2",  1, 0, 0, 0, 0);
      cycle("restart_load0", 0, 0, 0, 1, 0);
      cycle("restart_inc3",  1, 0, 0, 0, 0);
      cycle("restart_inc4",  1, 0, 0, 0, 0);
      cycle("restart_inc5",  1, 0, 0, 0, 0);

      // Random mix.
      for (int k = 0; k < 60; k++) begin
         cycle("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 255)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
